// File: rtl/dpram_port_driver_pkg.sv
// Shared types and constants for the dual-port RAM port driver.
//   state_e    : burst sequencer states
//   DEF_DW/AW/LW : default data, address and burst-length widths
//   RESP_DEPTH : read response buffer depth; also caps outstanding reads
package dpram_port_driver_pkg;

  localparam int unsigned DEF_DW     = 8;
  localparam int unsigned DEF_AW     = 6;
  localparam int unsigned DEF_LW     = 4;
  localparam int unsigned RESP_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// Small synchronous FIFO that buffers read responses as {last, data}.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_push, i_wdata : write one entry (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_rdata    : head entry (all zeros after reset)
//   o_count    : number of stored entries
module dpram_rsp_fifo
  import dpram_port_driver_pkg::*;
#(
  parameter int unsigned W     = DEF_DW + 1,
  parameter int unsigned DEPTH = RESP_DEPTH,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/dpram_port_driver.sv
// Burst initiator for one port of a synchronous dual-port RAM.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/len/data : burst command (len = beats - 1)
//   mem_addr/wdata/we/re, mem_rdata : RAM port pins (rdata one cycle after re)
//   rsp_valid/ready/data/last       : read response stream
//   busy                            : high whenever a burst is in progress
module dpram_port_driver
  import dpram_port_driver_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_mem_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] w_wdata_nxt;
  logic          r_mem_we;
  logic          w_we_nxt;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt_nxt;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          w_mem_re;
  logic          w_re_last;
  logic          w_pop;
  logic [OW-1:0] w_occ;
  logic          w_credit_ok;
  logic [CW-1:0] w_fifo_count;
  logic [DW:0]   w_fifo_head;

  // Read issue budget: entries left after this cycle's pop plus the read
  // whose data lands this cycle. Counting the pop lets a consumer that is
  // always ready sustain one beat per cycle with only two buffer slots.
  assign w_pop       = rsp_valid && rsp_ready;
  assign w_occ       = OW'(w_fifo_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_credit_ok = (w_occ < OW'(RESP_DEPTH));
  assign w_re_last   = w_mem_re && (r_cnt == '0);

  // Next-state and next-beat computation
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_we_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_mem_re    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt = cmd_addr;
          w_cnt_nxt  = cmd_len;
          if (cmd_write) begin
            w_wdata_nxt = cmd_data;
            w_we_nxt    = 1'b1;
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_mem_addr + AW'(1);
          w_wdata_nxt = r_mem_wdata + DW'(1);
          w_cnt_nxt   = r_cnt - LW'(1);
        end
      end
      ST_READ: begin
        if (w_credit_ok) begin
          w_mem_re = 1'b1;
          // Address stays on the final beat so it holds once idle
          if (r_cnt == '0) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_addr_nxt = r_mem_addr + AW'(1);
            w_cnt_nxt  = r_cnt - LW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((w_fifo_count == '0) && !r_inflight) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_we        <= 1'b0;
      r_cnt           <= '0;
      r_cmd_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_mem_addr      <= w_addr_nxt;
      r_mem_wdata     <= w_wdata_nxt;
      r_mem_we        <= w_we_nxt;
      r_cnt           <= w_cnt_nxt;
      r_cmd_ready     <= (w_state_nxt == ST_IDLE);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_inflight      <= w_mem_re;
      r_inflight_last <= w_re_last;
    end
  end

  // RAM data is captured the cycle after issue; reset drops it unseen
  dpram_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_last, mem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = w_mem_re;
  assign rsp_valid = (w_fifo_count != '0);
  assign rsp_data  = w_fifo_head[DW-1:0];
  assign rsp_last  = w_fifo_head[DW];

endmodule

// File: tb/tb_dpram_port_driver.sv
// Scoreboard bench for dpram_port_driver: directed bursts push expected RAM
// writes and read responses into queues; a negedge monitor pops and compares.
module tb_dpram_port_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] cmd_data;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int re_pulses = 0;

  logic [13:0] exp_wr[$];   // {addr, wdata}
  logic [8:0]  exp_rsp[$];  // {last, data}

  logic [7:0] ram [64];

  dpram_port_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model with registered read data
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops plus hold/exclusivity checks
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we || mem_re) chk("we_re_exclusive", 32'(mem_we && mem_re), 32'd0);
      if (mem_re) re_pulses++;
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
        else chk("write_beat", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'({rsp_last, rsp_data}), 32'hFFFF_FFFF);
        else chk("rsp_beat", 32'({rsp_last, rsp_data}), 32'(exp_rsp.pop_front()));
      end
      if (hold_prev) chk("rsp_hold", 32'({rsp_valid, rsp_last, rsp_data}), 32'({1'b1, hold_val}));
      hold_prev = rsp_valid && !rsp_ready;
      hold_val  = {rsp_last, rsp_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Offer a command at posedge+1; returns at posedge+1 after the accept edge
  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [3:0] l,
                          input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && exp_rsp.size() == 0) && n < 60) begin n++; @(negedge clk); end
    if (n >= 60) chk("idle_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_re"},    32'(mem_re),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int first_v;
    int n_v;
    int n_wait;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write burst addr 5, len 3, data A0
    exp_wr.push_back({6'd5, 8'hA0}); exp_wr.push_back({6'd6, 8'hA1});
    exp_wr.push_back({6'd7, 8'hA2}); exp_wr.push_back({6'd8, 8'hA3});
    send_cmd(1'b1, 6'd5, 4'd3, 8'hA0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_we_high", 32'(mem_we), 32'd1);
      chk("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
      chk("wr_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("wr_we_done", 32'(mem_we), 32'd0);
    chk("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("wr_busy_done", 32'(busy), 32'd0);
    chk("wr_addr_hold", 32'(mem_addr), 32'd8);
    @(posedge clk); #1;

    // Read back with consumer always ready
    exp_rsp.push_back({1'b0, 8'hA0}); exp_rsp.push_back({1'b0, 8'hA1});
    exp_rsp.push_back({1'b0, 8'hA2}); exp_rsp.push_back({1'b1, 8'hA3});
    rsp_ready = 1'b1;
    send_cmd(1'b0, 6'd5, 4'd3, 8'h00);
    first_v = 0; n_v = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_v++;
        if (first_v == 0) first_v = i;
      end
    end
    // rsp_valid rises two edges after the accepting edge, i.e. in cycle 3
    chk("rd_first_valid_cycle", 32'(first_v), 32'd3);
    chk("rd_valid_beats", 32'(n_v), 32'd4);
    wait_idle();

    // Same read with the consumer stalled for 5 cycles
    exp_rsp.push_back({1'b0, 8'hA0}); exp_rsp.push_back({1'b0, 8'hA1});
    exp_rsp.push_back({1'b0, 8'hA2}); exp_rsp.push_back({1'b1, 8'hA3});
    rsp_ready = 1'b0;
    re_pulses = 0;
    send_cmd(1'b0, 6'd5, 4'd3, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_data", 32'(rsp_data), 32'hA0);
      end
    end
    @(posedge clk);
    chk("stall_re_pulses", 32'(re_pulses), 32'd2);
    #1 rsp_ready = 1'b1;
    wait_idle();
    chk("stall_re_total", 32'(re_pulses), 32'd4);

    // Address and data wrap
    exp_wr.push_back({6'd62, 8'hFE}); exp_wr.push_back({6'd63, 8'hFF});
    exp_wr.push_back({6'd0, 8'h00});  exp_wr.push_back({6'd1, 8'h01});
    send_cmd(1'b1, 6'd62, 4'd3, 8'hFE);
    wait_idle();
    chk("wrap_writes_consumed", 32'(exp_wr.size()), 32'd0);

    // Reset in the middle of a stalled read after two issues
    rsp_ready = 1'b0;
    re_pulses = 0;
    send_cmd(1'b0, 6'd5, 4'd3, 8'h00);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("rst_mid_issues", 32'(re_pulses), 32'd2);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    re_pulses = 0;
    exp_rsp.push_back({1'b1, 8'h00});
    send_cmd(1'b0, 6'd0, 4'd0, 8'h00);
    wait_idle();
    chk("post_reset_re", 32'(re_pulses), 32'd1);

    // Back-to-back write then read with cmd_valid held high
    exp_wr.push_back({6'd10, 8'h55}); exp_wr.push_back({6'd11, 8'h56});
    exp_rsp.push_back({1'b0, 8'h55}); exp_rsp.push_back({1'b1, 8'h56});
    send_cmd(1'b1, 6'd10, 4'd1, 8'h55);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd10; cmd_len = 4'd1;
    n_wait = 0;
    @(negedge clk);
    while (!cmd_ready && n_wait < 20) begin n_wait++; @(negedge clk); end
    // Two write beats, then ready in the cycle after the last beat
    chk("b2b_accept_cycle", 32'(n_wait), 32'd2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    chk("final_wr_queue", 32'(exp_wr.size()), 32'd0);
    chk("final_rsp_queue", 32'(exp_rsp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_port_driver.md
Name: dpram_port_driver

Overview:
- Initiator for one port of a synchronous dual-port RAM (8-bit data, 6-bit address, separate write and read enables, registered read data).
- Accepts burst commands over a valid/ready interface and drives the RAM port pins.
- Reads return registered RAM data on a valid/ready response stream.
- Instantiated once per RAM port by test harnesses and memory-sharing logic.

Parameters:
- DW, 8, data width.
- AW, 6, address width.
- LW, 4, burst length field width; a burst is cmd_len+1 beats.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  LW  beats minus one.
- cmd_data  in  DW  first write value; beat k writes cmd_data+k mod 2^DW.
- mem_addr  out  AW  RAM port address.
- mem_wdata  out  DW  RAM port write data.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_rdata  in  DW  RAM registered read data, valid one cycle after mem_re.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DW  read data.
- rsp_last  out  1  marks the final beat of a read burst.
- busy  out  1  high from command accept until the last write is issued or the last response is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state. Outputs after reset:
  - cmd_ready=1.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_last=0, rsp_data=0, busy=0.
  - Response buffer and in-flight counter are emptied.
- Reset mid-burst abandons the burst. Reads already issued are discarded, never presented.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr, len, data, write.
  - Go to WRITE or READ on the next cycle. The first RAM beat is the cycle after accept.
- WRITE:
  - One beat per cycle, no stalls: mem_we=1, mem_addr=addr+k, mem_wdata=data+k.
  - After beat len, return to IDLE. The next command can be accepted in the cycle following the last beat.
- READ:
  - Issue mem_re=1, mem_addr=addr+k only when buffered count + in-flight reads < 2.
  - Each read's mem_rdata is captured into a 2-entry response FIFO on the cycle after issue.
  - After the last issue, go to DRAIN.
- DRAIN:
  - Wait until the FIFO is empty and nothing is in flight, then go to IDLE.
- Response stream:
  - rsp_valid = FIFO non-empty; rsp_data and rsp_last come from the FIFO head.
  - Pop on rsp_valid&rsp_ready.
  - A push and a pop in the same cycle keep the count unchanged.
  - With rsp_ready held high, throughput is 1 beat/cycle and first-data latency is 2 cycles after accept.
  - rsp_valid, once high, must not drop, and data must not change, until accepted.
- Address arithmetic: wraps mod 2^AW (e.g. start 62, len 3 → 62, 63, 0, 1). Write data wraps mod 2^DW.
- mem_we and mem_re are never both high.
- mem_addr and mem_wdata hold their last value when idle; only the enables qualify them.
- cmd_ready=0 in every state except IDLE.
- busy=0 exactly when the state is IDLE.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/WRITE/READ/DRAIN);
  - default DW/AW/LW constants;
  - RESP_DEPTH=2.
- One sub-module: dpram_rsp_fifo, a 2-entry synchronous FIFO with push/pop, count, and the same clk/rst_n. It carries {last, data}.

Test Plan:
- Write burst addr=5, len=3, data=0xA0 → mem_we high 4 consecutive cycles starting the cycle after accept; addr 5,6,7,8; wdata A0,A1,A2,A3; cmd_ready low during the burst, then high.
- Read back addr=5, len=3 with rsp_ready=1 (bench RAM model) → rsp A0,A1,A2,A3 on consecutive cycles; first rsp_valid 2 cycles after accept; rsp_last only on A3.
- Same read with rsp_ready=0 for 5 cycles → exactly 2 mem_re pulses then stall; rsp_data=A0 held stable; on release, all four beats arrive in order with no loss or duplication.
- Wrap: write addr=62, len=3, data=0xFE → addr 62,63,0,1; wdata FE,FF,00,01.
- Reset asserted mid-read after 2 issues → next cycle all outputs at reset values; a later read addr=0, len=0 returns a single beat with rsp_last=1 and no stale data.
- Back-to-back write then read commands with cmd_valid held high → second accept the cycle after the last write beat; mem_we and mem_re never both high.
